// File: rtl/tread_ctrl.sv
// tread_ctrl: maps d-pad or mixed analog stick to Battlezone tread Fw/Bk bits via sigma-delta pulses
module tread_ctrl #(
  parameter int TICK_DIV = 50000,
  parameter int DEADZONE = 16,
  parameter int DEADTIME = 4
) (
  input  logic        clk_50,
  input  logic        reset,
  input  logic [3:0]  joy,
  input  logic [15:0] joya,
  input  logic        analog_en,
  output logic        JoyW_Fw,
  output logic        JoyW_Bk,
  output logic        JoyX_Fw,
  output logic        JoyX_Bk,
  output logic        tick
);
  typedef enum logic [1:0] {IDLE, FWD, REV, DEAD} state_t;
  localparam int CW = $clog2(TICK_DIV + 1);
  localparam int DW = $clog2(DEADTIME + 2);
  localparam logic signed [9:0] DZ = 10'(DEADZONE);
  logic [CW-1:0] tcnt;
  logic [1:0] mode, mode_q, fwq, bkq, fw_q, bk_q;
  logic signed [9:0] ax, ay, yf, w_sum, x_sum;
  logic [9:0] w_mix, x_mix;
  logic [3:0] dig;
  logic [1:0][7:0] mag;
  function automatic logic signed [9:0] dz(input logic [7:0] v);
    logic signed [9:0] s;
    s = signed'({{2{v[7]}}, v});
    return (s > -DZ && s < DZ) ? 10'sd0 : s;
  endfunction
  // packs {fw, bk, mag}; a clamped 127 is promoted to full-on 128
  function automatic logic [9:0] mix(input logic signed [9:0] v);
    logic signed [9:0] c;
    logic [9:0] a;
    c = v > 10'sd127 ? 10'sd127 : v < -10'sd127 ? -10'sd127 : v;
    a = c[9] ? 10'(-c) : 10'(c);
    return {c > 10'sd0, c[9], a == 10'd127 ? 8'd128 : a[7:0]};
  endfunction
  assign tick = tcnt == CW'(TICK_DIV - 1);
  assign ax = dz(joya[7:0]);
  assign ay = dz(joya[15:8]);
  assign yf = ay == -10'sd128 ? 10'sd127 : -ay;
  assign w_sum = yf + ax;
  assign x_sum = yf - ax;
  assign w_mix = mix(w_sum);
  assign x_mix = mix(x_sum);
  assign mode = |joy ? 2'd1 : analog_en ? 2'd2 : 2'd0;
  always_comb begin
    case (joy)
      4'b1000: dig = 4'b1010;
      4'b1001: dig = 4'b1000;
      4'b0001: dig = 4'b1001;
      4'b0101: dig = 4'b0100;
      4'b0100: dig = 4'b0101;
      4'b0110: dig = 4'b0001;
      4'b0010: dig = 4'b0110;
      4'b1010: dig = 4'b0010;
      default: dig = 4'b0000;
    endcase
    fwq = mode == 2'd1 ? {dig[1], dig[3]} : mode == 2'd2 ? {x_mix[9], w_mix[9]} : 2'b00;
    bkq = mode == 2'd1 ? {dig[0], dig[2]} : mode == 2'd2 ? {x_mix[8], w_mix[8]} : 2'b00;
    mag[0] = mode == 2'd1 ? (|dig[3:2] ? 8'd128 : 8'd0) : mode == 2'd2 ? w_mix[7:0] : 8'd0;
    mag[1] = mode == 2'd1 ? (|dig[1:0] ? 8'd128 : 8'd0) : mode == 2'd2 ? x_mix[7:0] : 8'd0;
  end
  always_ff @(posedge clk_50) begin
    if (reset) begin
      tcnt <= '0;
      mode_q <= 2'd0;
    end else begin
      tcnt <= tick ? '0 : tcnt + 1'b1;
      if (tick) mode_q <= mode;
    end
  end
  for (genvar t = 0; t < 2; t++) begin : g_tread
    state_t st, st_n;
    logic [7:0] acc, acc_n, base, s, zcnt, zcnt_n;
    logic [DW-1:0] dcnt, dcnt_n;
    logic act, fw, bk;
    always_comb begin
      base = mode != mode_q ? 8'd0 : acc;
      s = base + mag[t];
      act = mag[t] == 8'd128 || (mag[t] != 8'd0 && s[7]);
      acc_n = mag[t] == 8'd0 ? 8'd0 : mag[t] == 8'd128 ? base : {1'b0, s[6:0]};
      case (st)
        IDLE:    st_n = fwq[t] ? FWD : bkq[t] ? REV : IDLE;
        FWD:     st_n = bkq[t] ? DEAD : (!fwq[t] && zcnt == 8'd128) ? IDLE : FWD;
        REV:     st_n = fwq[t] ? DEAD : (!bkq[t] && zcnt == 8'd128) ? IDLE : REV;
        default: st_n = dcnt <= DW'(1) ? (fwq[t] ? FWD : bkq[t] ? REV : IDLE) : DEAD;
      endcase
      zcnt_n = ((st_n == FWD || st_n == REV) && mag[t] == 8'd0) ? zcnt + 8'd1 : 8'd0;
      dcnt_n = st_n != DEAD ? '0 : st == DEAD ? dcnt - 1'b1 : DW'(DEADTIME);
    end
    always_ff @(posedge clk_50) begin
      if (reset) begin
        st <= IDLE;
        acc <= '0;
        zcnt <= '0;
        dcnt <= '0;
        fw <= 1'b0;
        bk <= 1'b0;
      end else if (tick) begin
        st <= st_n;
        acc <= acc_n;
        zcnt <= zcnt_n;
        dcnt <= dcnt_n;
        fw <= st_n == FWD && act;
        bk <= st_n == REV && act;
      end
    end
    assign fw_q[t] = fw;
    assign bk_q[t] = bk;
  end
  assign JoyW_Fw = fw_q[0];
  assign JoyW_Bk = bk_q[0];
  assign JoyX_Fw = fw_q[1];
  assign JoyX_Bk = bk_q[1];
endmodule
